// File: rtl/mem_wb_unit.sv
// MEM/WB pipeline stage: load alignment, write-back select,
// WB register bundle and retired-instruction counter.
module mem_wb_unit #(
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    INSTR_VALID_EXMEM,
    input  logic                    REG_WRITE_EN_EXMEM,
    input  logic [1:0]              WB_VALUE_SEL_EXMEM,
    input  logic                    MEM_READ_EN_EXMEM,
    input  logic [31:0]             PC_EXMEM,
    input  logic [31:0]             RESULT,
    input  logic [31:0]             READ_DATA,
    input  logic [2:0]              FUNC3_EXMEM,
    input  logic [4:0]              REG_WRITE_ADDR_EXMEM,
    input  logic                    MEM_BUSYWAIT,
    output logic                    REG_WRITE_EN_WB,
    output logic [4:0]              REG_WRITE_ADDR_WB,
    output logic                    MEM_READ_EN_WB,
    output logic [31:0]             WB_DATA,
    output logic                    WB_VALID,
    output logic [RETIRE_CNT_W-1:0] INSTR_RETIRED
);

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic        mrd;
        logic [31:0] data;
        logic        valid;
    } wb_t;

    wb_t                    wb_q;
    logic [RETIRE_CNT_W-1:0] cnt_q;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [31:0]            ld_data;
    logic [31:0]            wb_val;
    logic                   wr_ok;

    // Pick the addressed byte and halfword lanes out of the read word.
    always_comb begin
        ld_byte = READ_DATA[7:0];
        unique case (RESULT[1:0])
            2'd0: ld_byte = READ_DATA[7:0];
            2'd1: ld_byte = READ_DATA[15:8];
            2'd2: ld_byte = READ_DATA[23:16];
            2'd3: ld_byte = READ_DATA[31:24];
            default: ld_byte = READ_DATA[7:0];
        endcase
        ld_half = RESULT[1] ? READ_DATA[31:16]
                            : READ_DATA[15:0];
    end

    // Extend the selected lane according to the load width/sign code.
    always_comb begin
        ld_data = READ_DATA;
        case (FUNC3_EXMEM)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {24'd0, ld_byte};
            3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101: ld_data = {16'd0, ld_half};
            default: ld_data = READ_DATA;
        endcase
    end

    // Choose the value written back to the register file.
    always_comb begin
        wb_val = RESULT;
        unique case (WB_VALUE_SEL_EXMEM)
            2'b00: wb_val = RESULT;
            2'b01: wb_val = ld_data;
            2'b10: wb_val = PC_EXMEM + 32'd4;
            2'b11: wb_val = RESULT;
            default: wb_val = RESULT;
        endcase
        wr_ok = INSTR_VALID_EXMEM
              & REG_WRITE_EN_EXMEM
              & (REG_WRITE_ADDR_EXMEM != 5'd0);
    end

    // WB register: capture when not stalled, bubble while stalled.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wb_q  <= '0;
            cnt_q <= '0;
        end else if (MEM_BUSYWAIT) begin
            wb_q.we    <= 1'b0;
            wb_q.mrd   <= 1'b0;
            wb_q.valid <= 1'b0;
        end else begin
            wb_q.we    <= wr_ok;
            wb_q.rd    <= REG_WRITE_ADDR_EXMEM;
            wb_q.mrd   <= INSTR_VALID_EXMEM
                        & MEM_READ_EN_EXMEM;
            wb_q.data  <= wb_val;
            wb_q.valid <= INSTR_VALID_EXMEM;
            if (INSTR_VALID_EXMEM)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign REG_WRITE_EN_WB   = wb_q.we;
    assign REG_WRITE_ADDR_WB = wb_q.rd;
    assign MEM_READ_EN_WB    = wb_q.mrd;
    assign WB_DATA           = wb_q.data;
    assign WB_VALID          = wb_q.valid;
    assign INSTR_RETIRED     = cnt_q;

endmodule

// File: tb/tb_mem_wb_unit.sv
// Directed bench for mem_wb_unit: reset, load alignment,
// write-back select, stalls, x0/bubbles and counter wrap.
module tb_mem_wb_unit;

    logic        CLK;
    logic        RESET;
    logic        INSTR_VALID_EXMEM;
    logic        REG_WRITE_EN_EXMEM;
    logic [1:0]  WB_VALUE_SEL_EXMEM;
    logic        MEM_READ_EN_EXMEM;
    logic [31:0] PC_EXMEM;
    logic [31:0] RESULT;
    logic [31:0] READ_DATA;
    logic [2:0]  FUNC3_EXMEM;
    logic [4:0]  REG_WRITE_ADDR_EXMEM;
    logic        MEM_BUSYWAIT;

    logic        REG_WRITE_EN_WB;
    logic [4:0]  REG_WRITE_ADDR_WB;
    logic        MEM_READ_EN_WB;
    logic [31:0] WB_DATA;
    logic        WB_VALID;
    logic [31:0] INSTR_RETIRED;

    logic        we4;
    logic [4:0]  rd4;
    logic        mrd4;
    logic [31:0] data4;
    logic        valid4;
    logic [3:0]  cnt4;

    int checks;
    int failures;
    int exp_cnt;
    int we_pulses;

    mem_wb_unit dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .INSTR_VALID_EXMEM    (INSTR_VALID_EXMEM),
        .REG_WRITE_EN_EXMEM   (REG_WRITE_EN_EXMEM),
        .WB_VALUE_SEL_EXMEM   (WB_VALUE_SEL_EXMEM),
        .MEM_READ_EN_EXMEM    (MEM_READ_EN_EXMEM),
        .PC_EXMEM             (PC_EXMEM),
        .RESULT               (RESULT),
        .READ_DATA            (READ_DATA),
        .FUNC3_EXMEM          (FUNC3_EXMEM),
        .REG_WRITE_ADDR_EXMEM (REG_WRITE_ADDR_EXMEM),
        .MEM_BUSYWAIT         (MEM_BUSYWAIT),
        .REG_WRITE_EN_WB      (REG_WRITE_EN_WB),
        .REG_WRITE_ADDR_WB    (REG_WRITE_ADDR_WB),
        .MEM_READ_EN_WB       (MEM_READ_EN_WB),
        .WB_DATA              (WB_DATA),
        .WB_VALID             (WB_VALID),
        .INSTR_RETIRED        (INSTR_RETIRED)
    );

    mem_wb_unit #(.RETIRE_CNT_W(4)) dut4 (
        .CLK                  (CLK),
        .RESET                (RESET),
        .INSTR_VALID_EXMEM    (INSTR_VALID_EXMEM),
        .REG_WRITE_EN_EXMEM   (REG_WRITE_EN_EXMEM),
        .WB_VALUE_SEL_EXMEM   (WB_VALUE_SEL_EXMEM),
        .MEM_READ_EN_EXMEM    (MEM_READ_EN_EXMEM),
        .PC_EXMEM             (PC_EXMEM),
        .RESULT               (RESULT),
        .READ_DATA            (READ_DATA),
        .FUNC3_EXMEM          (FUNC3_EXMEM),
        .REG_WRITE_ADDR_EXMEM (REG_WRITE_ADDR_EXMEM),
        .MEM_BUSYWAIT         (MEM_BUSYWAIT),
        .REG_WRITE_EN_WB      (we4),
        .REG_WRITE_ADDR_WB    (rd4),
        .MEM_READ_EN_WB       (mrd4),
        .WB_DATA              (data4),
        .WB_VALID             (valid4),
        .INSTR_RETIRED        (cnt4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".we"},    {31'd0, REG_WRITE_EN_WB}, 32'd0);
        chk({tag, ".rd"},    {27'd0, REG_WRITE_ADDR_WB}, 32'd0);
        chk({tag, ".mrd"},   {31'd0, MEM_READ_EN_WB}, 32'd0);
        chk({tag, ".data"},  WB_DATA, 32'd0);
        chk({tag, ".valid"}, {31'd0, WB_VALID}, 32'd0);
        chk({tag, ".cnt"},   INSTR_RETIRED, 32'd0);
    endtask

    task automatic drive(input logic v, input logic we,
                         input logic [1:0] sel, input logic mr,
                         input logic [31:0] res,
                         input logic [2:0] f3,
                         input logic [4:0] rd);
        INSTR_VALID_EXMEM    = v;
        REG_WRITE_EN_EXMEM   = we;
        WB_VALUE_SEL_EXMEM   = sel;
        MEM_READ_EN_EXMEM    = mr;
        RESULT               = res;
        FUNC3_EXMEM          = f3;
        REG_WRITE_ADDR_EXMEM = rd;
    endtask

    logic [2:0]  ld_f3  [8];
    logic [1:0]  ld_off [8];
    logic [31:0] ld_exp [8];

    initial begin
        checks    = 0;
        failures  = 0;
        exp_cnt   = 0;
        we_pulses = 0;

        ld_f3[0] = 3'b000; ld_off[0] = 2'd0; ld_exp[0] = 32'h00000001;
        ld_f3[1] = 3'b000; ld_off[1] = 2'd1; ld_exp[1] = 32'h0000007F;
        ld_f3[2] = 3'b000; ld_off[2] = 2'd2; ld_exp[2] = 32'hFFFFFFFF;
        ld_f3[3] = 3'b000; ld_off[3] = 2'd3; ld_exp[3] = 32'hFFFFFF80;
        ld_f3[4] = 3'b100; ld_off[4] = 2'd3; ld_exp[4] = 32'h00000080;
        ld_f3[5] = 3'b001; ld_off[5] = 2'd2; ld_exp[5] = 32'hFFFF80FF;
        ld_f3[6] = 3'b101; ld_off[6] = 2'd0; ld_exp[6] = 32'h00007F01;
        ld_f3[7] = 3'b010; ld_off[7] = 2'd1; ld_exp[7] = 32'h80FF7F01;

        RESET        = 1'b0;
        MEM_BUSYWAIT = 1'b0;
        PC_EXMEM     = 32'h0;
        READ_DATA    = 32'h0;
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h77, 3'b010, 5'd9);
        step();
        step();
        chk_zero("rst_init");

        // release and retire five ADDs
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 2'b00, 1'b0,
                  32'h100 + i, 3'b010, 5'd7);
            step();
        end
        chk("pre_rst.cnt", INSTR_RETIRED, 32'd5);
        chk("pre_rst.data", WB_DATA, 32'h104);

        // asynchronous reset mid-run, no edge in between
        #1;
        RESET = 1'b0;
        #1;
        chk_zero("rst_async");

        @(negedge CLK);
        chk_zero("rst_hold");
        RESET = 1'b1;
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h1234, 3'b010, 5'd3);
        step();
        exp_cnt = 1;
        chk("add.data", WB_DATA, 32'h1234);
        chk("add.rd", {27'd0, REG_WRITE_ADDR_WB}, 32'd3);
        chk("add.we", {31'd0, REG_WRITE_EN_WB}, 32'd1);
        chk("add.valid", {31'd0, WB_VALID}, 32'd1);
        chk("add.cnt", INSTR_RETIRED, 32'd1);

        // load alignment
        READ_DATA = 32'h80FF7F01;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 2'b01, 1'b1,
                  {30'h0400, ld_off[i]}, ld_f3[i], 5'd5);
            step();
            exp_cnt++;
            chk($sformatf("load%0d.data", i), WB_DATA, ld_exp[i]);
            chk($sformatf("load%0d.mrd", i),
                {31'd0, MEM_READ_EN_WB}, 32'd1);
        end
        chk("load.cnt", INSTR_RETIRED, exp_cnt);

        // write-back select
        PC_EXMEM = 32'hFFFFFFFC;
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h55, 3'b000, 5'd1);
        step();
        exp_cnt++;
        chk("sel10.data", WB_DATA, 32'h0);
        chk("sel10.mrd", {31'd0, MEM_READ_EN_WB}, 32'd0);
        drive(1'b1, 1'b1, 2'b11, 1'b0, 32'hABCD, 3'b000, 5'd2);
        step();
        exp_cnt++;
        chk("sel11.data", WB_DATA, 32'hABCD);

        // stall: three bubbles then one capture
        drive(1'b1, 1'b1, 2'b01, 1'b1, 32'h2000, 3'b010, 5'd8);
        READ_DATA    = 32'hDEADBEEF;
        MEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d.valid", i),
                {31'd0, WB_VALID}, 32'd0);
            chk($sformatf("stall%0d.data", i), WB_DATA, 32'hABCD);
            chk($sformatf("stall%0d.rd", i),
                {27'd0, REG_WRITE_ADDR_WB}, 32'd2);
            chk($sformatf("stall%0d.cnt", i), INSTR_RETIRED, exp_cnt);
            if (REG_WRITE_EN_WB) we_pulses++;
        end
        MEM_BUSYWAIT = 1'b0;
        step();
        exp_cnt++;
        if (REG_WRITE_EN_WB) we_pulses++;
        chk("stall_go.valid", {31'd0, WB_VALID}, 32'd1);
        chk("stall_go.mrd", {31'd0, MEM_READ_EN_WB}, 32'd1);
        chk("stall_go.data", WB_DATA, 32'hDEADBEEF);
        chk("stall_go.cnt", INSTR_RETIRED, exp_cnt);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 3'b000, 5'd0);
        step();
        if (REG_WRITE_EN_WB) we_pulses++;
        chk("stall.we_pulses", we_pulses, 32'd1);

        // x0 destination still retires
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h99, 3'b000, 5'd0);
        step();
        exp_cnt++;
        chk("x0.we", {31'd0, REG_WRITE_EN_WB}, 32'd0);
        chk("x0.valid", {31'd0, WB_VALID}, 32'd1);
        chk("x0.cnt", INSTR_RETIRED, exp_cnt);

        // bubble with write enable set
        drive(1'b0, 1'b1, 2'b01, 1'b1, 32'h44, 3'b000, 5'd4);
        step();
        chk("bub.we", {31'd0, REG_WRITE_EN_WB}, 32'd0);
        chk("bub.mrd", {31'd0, MEM_READ_EN_WB}, 32'd0);
        chk("bub.valid", {31'd0, WB_VALID}, 32'd0);
        chk("bub.cnt", INSTR_RETIRED, exp_cnt);

        // reset during a stall drops the pending load
        drive(1'b1, 1'b1, 2'b01, 1'b1, 32'h3000, 3'b010, 5'd6);
        MEM_BUSYWAIT = 1'b1;
        step();
        RESET = 1'b0;
        #1;
        chk_zero("rst_stall");
        @(negedge CLK);
        RESET        = 1'b1;
        MEM_BUSYWAIT = 1'b0;

        // 17 valid instructions wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 2'b00, 1'b0,
                  32'h10 + i, 3'b000, 5'd10);
            step();
        end
        chk("wrap.cnt4", {28'd0, cnt4}, 32'd1);
        chk("wrap.cnt32", INSTR_RETIRED, 32'd17);
        chk("wrap.data4", data4, 32'h20);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_unit.md
# mem_wb_unit

Pipeline stage between MEM and WB of the RV32IM core. Each cycle the memory stage is not stalled, it captures the instruction leaving MEM, aligns and sign/zero-extends load data by FUNC3 and address offset, and selects the write-back value. It registers the result into the WB stage and drives the register-file write port and the WB-side forwarding signals. It also keeps a retired-instruction counter.

## Interface
- RETIRE_CNT_W, default 32: width of the retired-instruction counter.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- INSTR_VALID_EXMEM  in  1  instruction in MEM is real (0 = bubble).
- REG_WRITE_EN_EXMEM  in  1  instruction writes rd.
- WB_VALUE_SEL_EXMEM  in  2  write-back source select.
- MEM_READ_EN_EXMEM  in  1  instruction is a load.
- PC_EXMEM  in  32  PC of the instruction in MEM.
- RESULT  in  32  ALU result / memory address.
- READ_DATA  in  32  word read from the cache controller, word-aligned at RESULT[31:2].
- FUNC3_EXMEM  in  3  load width/sign code.
- REG_WRITE_ADDR_EXMEM  in  5  rd.
- MEM_BUSYWAIT  in  1  cache controller stall.
- REG_WRITE_EN_WB  out  1  register-file write enable.
- REG_WRITE_ADDR_WB  out  5  register-file write address.
- MEM_READ_EN_WB  out  1  WB instruction is a load (to the memory forwarding unit).
- WB_DATA  out  32  register-file write data; also the forwarded value to the MEM data-select mux.
- WB_VALID  out  1  WB holds a real instruction.
- INSTR_RETIRED  out  RETIRE_CNT_W  count of retired instructions.

## Operation
- Load alignment is combinational on READ_DATA, using off = RESULT[1:0]:
  - 000 LB: byte at lane off, sign-extended.
  - 100 LBU: byte at lane off, zero-extended.
  - 001 LH: halfword at lane RESULT[1], sign-extended.
  - 101 LHU: halfword at lane RESULT[1], zero-extended.
  - 010 LW: full word; off ignored.
  - Other FUNC3 codes: full word.
  - Lane 0 is bits [7:0]. Misaligned halfwords are not detected; the design ignores RESULT[0] for LH/LHU.
- Write-back select:
  - 00: RESULT.
  - 01: aligned load data.
  - 10: PC_EXMEM + 4, wrapping mod 2^32.
  - 11: reserved, selects RESULT.
- Capture (advance) happens when MEM_BUSYWAIT = 0. At the next edge all WB registers load from the MEM-side inputs.
- Stall (MEM_BUSYWAIT = 1): at the next edge the stage loads a bubble.
  - REG_WRITE_EN_WB = 0, MEM_READ_EN_WB = 0, WB_VALID = 0.
  - REG_WRITE_ADDR_WB and WB_DATA hold their previous values.
  - The stalled instruction stays in MEM and is captured exactly once, on the first cycle BUSYWAIT drops.
- An input bubble (INSTR_VALID_EXMEM = 0) is captured with REG_WRITE_EN_WB and MEM_READ_EN_WB forced to 0.
- REG_WRITE_EN_WB is forced to 0 when REG_WRITE_ADDR_EXMEM = 0, so x0 is never written.
- Retire counter: INSTR_RETIRED increments by 1 at each edge where capture occurs with INSTR_VALID_EXMEM = 1. It wraps from all-ones to 0.

## Timing
- Reset (RESET = 0, asynchronous): every output is 0, including WB_DATA, REG_WRITE_ADDR_WB and INSTR_RETIRED. Outputs stay 0 while RESET is low.
- Deassertion of RESET is sampled synchronously. The first capture is at the first rising edge with RESET = 1.
- Latency is 1 cycle from MEM inputs to WB outputs. All outputs are registered; there is no combinational input→output path.
- READ_DATA is sampled only at the capture edge. It must be valid in the cycle BUSYWAIT is 0.
- Reset asserted during a stall discards the pending instruction and leaves the counter at 0.
- BUSYWAIT held high for N cycles produces N bubbles in WB, followed by one capture.

## Test plan
- Reset check: assert RESET = 0 mid-run with counter = 5 → all outputs read 0 immediately without waiting for an edge. After release, the first valid ADD (rd = 3, RESULT = 0x1234) gives WB_DATA = 0x1234, REG_WRITE_ADDR_WB = 3 and INSTR_RETIRED = 1 after one edge.
- Load alignment: READ_DATA = 0x80FF7F01 with RESULT low bits 0–3.
  - LB at 0,1,2,3 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - LBU at 3 → 0x00000080.
  - LH at 2 → 0xFFFF80FF.
  - LHU at 0 → 0x00007F01.
  - LW → 0x80FF7F01.
- WB select: PC_EXMEM = 0xFFFFFFFC with SEL = 10 → WB_DATA = 0x00000000. SEL = 11 with RESULT = 0xABCD → 0xABCD.
- Stall: valid load with BUSYWAIT high for 3 cycles, then low.
  - WB_VALID sequence is 0,0,0,1.
  - REG_WRITE_EN_WB pulses exactly once and MEM_READ_EN_WB = 1 in that cycle.
  - INSTR_RETIRED increments by exactly 1.
- x0 and bubbles:
  - rd = 0 with REG_WRITE_EN_EXMEM = 1 → REG_WRITE_EN_WB = 0 and the counter still increments.
  - INSTR_VALID_EXMEM = 0 with REG_WRITE_EN_EXMEM = 1 → no write and no increment.
- Counter wrap: with RETIRE_CNT_W = 4, 17 valid instructions → INSTR_RETIRED = 1.
